// File: rtl/router_pkg.sv
// Shared types and default widths for the router packet input port.
package router_pkg;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_MAX_WORDS = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_NBITS_W   = $clog2(DEF_WORD_W + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, TRUNC} portin_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  addr;
        logic [DEF_WORD_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic                   err;
        logic [DEF_NBITS_W-1:0] nbits;
    } portin_entry_t;
endpackage

// File: rtl/router_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head reads as zero while empty.
module router_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;
    assign pop_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= push_data;
    end
endmodule

// File: rtl/router_portin_pkt.sv
// Bit-serial packet input port: deserialises address and payload words into a FIFO.
//   state | meaning
//   IDLE  | waiting for frame_n low
//   ADDR  | collecting address bits (valid_n high)
//   DATA  | collecting payload bits into the current word
//   TRUNC | MAX_WORDS already pushed; discarding payload until packet end
module router_portin_pkt
    import router_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        frame_n,
    input  logic                        valid_n,
    input  logic                        di,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        out_err,
    output logic [$clog2(WORD_W+1)-1:0] out_nbits,
    output logic                        ovf
);
    localparam int NBITS_W = $clog2(WORD_W + 1);
    localparam int CNTA_W  = $clog2(ADDR_W + 1);
    localparam int CNTW_W  = $clog2(MAX_WORDS + 1);
    localparam int ENTRY_W = ADDR_W + WORD_W + 3 + NBITS_W;

    portin_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNTA_W-1:0]   cnta_q, cnta_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [NBITS_W-1:0]  cntp_q, cntp_d;
    logic [CNTW_W-1:0]   cntw_q, cntw_d;
    logic                err_q, err_d;
    logic                sop_q, sop_d;

    logic                take_bit, abort, trunc_end, go_idle;
    logic                push, err_eff;
    logic [WORD_W-1:0]   new_word, e_data;
    logic [NBITS_W-1:0]  e_nbits;
    logic                e_eop, e_err;
    logic [ENTRY_W-1:0]  push_entry, head;
    logic                full, empty, drop, pop;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnta_d    = cnta_q;
        word_d    = word_q;
        cntp_d    = cntp_q;
        cntw_d    = cntw_q;
        err_d     = err_q;
        sop_d     = sop_q;
        take_bit  = 1'b0;
        abort     = 1'b0;
        trunc_end = 1'b0;
        go_idle   = 1'b0;
        push      = 1'b0;
        new_word  = word_q | (WORD_W'(di) << cntp_q);
        // A payload bit straight from IDLE, or before a full address, marks the packet bad.
        err_eff   = err_q || (state_q == IDLE) ||
                    ((state_q == ADDR) && (cnta_q < CNTA_W'(ADDR_W)));
        e_data    = new_word;
        e_nbits   = cntp_q + NBITS_W'(1);
        e_eop     = 1'b0;
        e_err     = err_eff;

        case (state_q)
            IDLE, ADDR: begin
                if (!frame_n && valid_n) begin
                    if (cnta_q < CNTA_W'(ADDR_W)) begin
                        addr_d = addr_q | (ADDR_W'(di) << cnta_q);
                        cnta_d = cnta_q + CNTA_W'(1);
                    end
                    state_d = ADDR;
                end else if (!valid_n && !(frame_n && (state_q == IDLE))) begin
                    take_bit = 1'b1;
                end else if ((state_q == ADDR) && frame_n) begin
                    abort = 1'b1;
                end
            end
            DATA: begin
                if (!valid_n)     take_bit = 1'b1;
                else if (frame_n) abort    = 1'b1;
            end
            TRUNC: begin
                if (frame_n) trunc_end = 1'b1;
            end
            default: ;
        endcase

        if (take_bit) begin
            if (cntw_q == CNTW_W'(MAX_WORDS)) begin
                if (frame_n) trunc_end = 1'b1;
                else         state_d   = TRUNC;
            end else begin
                push  = frame_n || (cntp_q == NBITS_W'(WORD_W - 1));
                e_eop = frame_n;
                err_d = err_eff;
                if (frame_n) begin
                    go_idle = 1'b1;
                end else if (push) begin
                    word_d  = '0;
                    cntp_d  = '0;
                    cntw_d  = cntw_q + CNTW_W'(1);
                    sop_d   = 1'b0;
                    state_d = DATA;
                end else begin
                    word_d  = new_word;
                    cntp_d  = cntp_q + NBITS_W'(1);
                    state_d = DATA;
                end
            end
        end

        if (abort) begin
            push    = 1'b1;
            e_data  = word_q;
            e_nbits = cntp_q;
            e_eop   = 1'b1;
            e_err   = 1'b1;
            go_idle = 1'b1;
        end

        if (trunc_end) begin
            push    = 1'b1;
            e_data  = '0;
            e_nbits = '0;
            e_eop   = 1'b1;
            e_err   = 1'b1;
            go_idle = 1'b1;
        end

        if (go_idle) begin
            state_d = IDLE;
            addr_d  = '0;
            cnta_d  = '0;
            word_d  = '0;
            cntp_d  = '0;
            cntw_d  = '0;
            err_d   = 1'b0;
            sop_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnta_q  <= '0;
            word_q  <= '0;
            cntp_q  <= '0;
            cntw_q  <= '0;
            err_q   <= 1'b0;
            sop_q   <= 1'b1;
            ovf     <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnta_q  <= '0;
            word_q  <= '0;
            cntp_q  <= '0;
            cntw_q  <= '0;
            err_q   <= 1'b0;
            sop_q   <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnta_q  <= cnta_d;
            word_q  <= word_d;
            cntp_q  <= cntp_d;
            cntw_q  <= cntw_d;
            err_q   <= err_d;
            sop_q   <= sop_d;
            if (drop) ovf <= 1'b1;
        end
    end

    assign push_entry = {addr_q, e_data, sop_q, e_eop, e_err, e_nbits};
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign {out_addr, out_data, out_sop, out_eop, out_err, out_nbits} = head;

    router_sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .drop      (drop)
    );
endmodule

// File: doc/router_portin_pkt.md
Name: router_portin_pkt

Overview:
- Parametrised successor to the router serial input port.
- Deserialises the frame_n/valid_n/di bit-serial protocol into an address and a stream of WORD_W-bit payload words.
- Supports multi-word packets up to MAX_WORDS, flags malformed, aborted and truncated packets, and buffers words in a DEPTH-entry FIFO.
- Drains to the switch core over a valid/ready handshake.

Parameters:
ADDR_W, 4, destination address bits captured per packet
WORD_W, 32, payload word width
MAX_WORDS, 4, maximum payload words per packet; excess bits truncated
DEPTH, 8, output FIFO entries (power of 2, >=2)

Ports:
clock  in  1  single clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush; priority over all but reset
frame_n  in  1  low while packet active; high on the final payload bit
valid_n  in  1  high = address bit, low = payload bit
di  in  1  serial data, LSB first
out_valid  out  1  FIFO head entry valid
out_ready  in  1  consumer accepts head entry when out_valid&out_ready
out_addr  out  ADDR_W  packet address of head entry
out_data  out  WORD_W  payload word; bits above nbits are zero
out_sop  out  1  first entry of packet
out_eop  out  1  last entry of packet
out_err  out  1  packet malformed, aborted or truncated (valid on every entry of a packet from the point of detection)
out_nbits  out  $clog2(WORD_W+1)  valid bits in out_data, 0..WORD_W
ovf  out  1  sticky: an entry was dropped because the FIFO was full

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0. FIFO empty. State IDLE. Counters and shift register 0.
- clear=1 at an edge:
  - Same effect as reset, synchronously. Any packet in progress is discarded; the next entry carries sop=1.
- State machine: IDLE, ADDR, DATA, TRUNC.
  - IDLE:
    - frame_n=0, valid_n=1 -> ADDR; capture di as addr bit 0.
    - frame_n=0, valid_n=0 -> DATA; capture di as payload bit 0; err=1 (no address); addr=0.
    - Any other input -> no action.
  - ADDR:
    - valid_n=1, frame_n=0 -> addr[cnta]=di while cnta<ADDR_W; extra address bits are ignored.
    - valid_n=0 -> DATA; capture di as payload bit 0; err=1 if fewer than ADDR_W address bits were seen; missing addr bits read 0.
  - DATA:
    - Each valid_n=0 cycle shifts di into bit position cntp of the current word.
    - When WORD_W bits are collected, push entry {addr, word, sop, eop=0, err, nbits=WORD_W}. sop=1 only for the first push of the packet.
    - A cycle with frame_n=0, valid_n=1 inside DATA is a wait cycle: no bit is captured.
  - Final bit (frame_n=1, valid_n=0 in ADDR or DATA):
    - Bit captured; push the current word with eop=1 and nbits = bits collected (1..WORD_W) -> IDLE.
    - If this bit completes a full word, that single push carries eop=1 and nbits=WORD_W.
  - Abort (frame_n=1, valid_n=1 in ADDR, DATA or TRUNC):
    - Push terminating entry with partial data, nbits = bits collected (0 allowed), eop=1, err=1 -> IDLE.
  - Truncation:
    - When MAX_WORDS words have been pushed and more payload bits arrive -> TRUNC; those bits are discarded.
    - Packet end or abort in TRUNC pushes one terminating entry: nbits=0, data=0, eop=1, err=1.
    - A packet of exactly MAX_WORDS*WORD_W bits is not truncated; its last word carries eop=1.
- Latency:
  - An entry pushed at edge k is visible at the FIFO head (first-word fall-through) after edge k if the FIFO was empty.
- FIFO:
  - Pop when out_valid&out_ready.
  - Push while full with a simultaneous pop: accepted, count unchanged.
  - Push while full without a pop: entry dropped, ovf<=1 (sticky until reset/clear).
  - Push and pop into an empty FIFO in the same cycle: no pop, since out_valid is 0.
- Widths:
  - cntp sized for WORD_W; word counter sized for MAX_WORDS.
  - Pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.

Decomposition:
- Package router_pkg:
  - ADDR_W/WORD_W defaults.
  - portin_state_e enum (IDLE, ADDR, DATA, TRUNC).
  - portin_entry_t struct {addr, data, sop, eop, err, nbits}.
- Sub-module router_sync_fifo:
  - Parametrised on entry width and DEPTH; FWFT.
  - Provides push, full, pop, empty and a drop indication.

Test Plan:
1. Addr 4'hA (bits 0,1,0,1), payload 0xDEADBEEF LSB first, last bit with frame_n=1 -> one entry: addr=A, data=DEADBEEF, sop=1, eop=1, err=0, nbits=32; out_valid high after the final edge.
2. Addr 3, 40 payload bits -> entry0 sop=1 eop=0 nbits=32; entry1 sop=0 eop=1 nbits=8, data[31:8]=0.
3. Only 2 address bits, then 32 payload bits -> err=1 on the entry, addr[3:2]=0. Abort after 5 payload bits -> entry nbits=5, eop=1, err=1.
4. 130-bit payload with MAX_WORDS=4 -> 4 full entries (eop=0), then terminating entry nbits=0, eop=1, err=1. A 128-bit payload gives 4 entries, the last with eop=1, err=0.
5. out_ready=0 and 9 single-word packets with DEPTH=8 -> 8 entries held, 9th dropped, ovf=1. Then out_ready=1 -> 8 pops in order. clear -> out_valid=0, ovf=0.
6. reset_n pulsed low mid-payload, asynchronously between edges -> outputs immediately 0. The next packet produces a clean entry with sop=1 and err=0.
